xd_skip_fma: RTL and testbench
==============================

# xd_skip_fma

Parametrised successor of the D-skip stage in the Mamba-2 SSM output path: computes out[b,h,p] = D[h] × x[b,h,p] over a B×H×P FP16 tensor using PAR_H parallel FP16 multiplier lanes. It optionally fuses the residual add, out = y_in + D·x, so the separate y-accumulate pass disappears. It sits after the SSM state-scan/readout block and before the gating/norm stage. It adds ragged-head handling (H not a multiple of PAR_H), per-lane valid tagging, a busy flag and an explicit done/ack handshake.

## Interface
- B, default 1: batch count.
- H, default 24: head count, ≥1, need not be a multiple of PAR_H.
- P, default 64: head dim.
- DW, default 16: element width; FP16 only, fixed at 16.
- M_LAT, default 6: fp16_mult_wrapper latency in cycles.
- A_LAT, default 11: fp16_add_wrapper latency; used only with XD_SKIP_ADD_EN.
- PAR_H, default 12: parallel lanes, 1..H.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- acc_sig  in  1  downstream ack; sampled only in DONE.
- D_flat  in  H*DW  per-head scale; element h at bits [(h+1)*DW-1 -: DW].
- x_flat  in  B*H*P*DW  input tensor; flat index i = b*H*P + h*P + p.
- y_in_flat  in  B*H*P*DW  residual tensor, same indexing; exists only with XD_SKIP_ADD_EN.
- out_flat  out  B*H*P*DW  result tensor, same indexing, registered.
- busy  out  1  high in CALC and FLUSH.
- done  out  1  high in DONE.

## Operation
- FSM states: IDLE, CALC, FLUSH, DONE.
  - IDLE→CALC when start=1. The counters b, hg and p are cleared.
  - CALC→FLUSH after the last issue.
  - FLUSH→DONE after L cycles.
  - DONE→IDLE when acc_sig=1.
- Issue order: p fastest, then head group hg = 0, PAR_H, 2·PAR_H, …, then b.
  - Each CALC cycle issues one (b, hg, p) tuple to all lanes.
  - N_ISSUE = B·P·ceil(H/PAR_H).
- Lane i in group hg is enabled iff hg+i < H.
  - Disabled lanes get valid_in=0 and never write.
  - Every lane's valid and tag are carried alongside it.
- Each enabled lane carries a tag {flat index} through a shift register whose depth matches the pipeline latency L.
  - L = M_LAT + 1 without the macro.
  - L = M_LAT + A_LAT + 2 with it.
  - On a lane's output valid, out_flat[tag] is written with the lane result.
  - No other out_flat element changes.
- Arithmetic: IEEE FP16, with rounding and NaN/Inf/denormal behaviour as implemented by the shared fp16 wrapper IPs; no extra rounding. With the add, the sum is y_in + (D·x).
- out_flat holds its value after done until it is overwritten by the next job. It is not cleared on start.
- While busy or done:
  - start is ignored.
  - x_flat, D_flat and y_in_flat must be held stable from start until done. The block does not capture them.
- acc_sig outside DONE is ignored. If start and acc_sig are both high in DONE, acc_sig wins and start is dropped; start must be re-asserted in IDLE.
- Reset, including mid-CALC/FLUSH:
  - state=IDLE; busy=0, done=0, out_flat=0.
  - All lane valid and tag pipelines are cleared, so no stale write occurs after reset release.

## Timing
- Reset values: busy=0, done=0, out_flat all zero.
- Let start be sampled at edge 0.
  - busy rises after edge 0.
  - Issues occur at edges 1..N_ISSUE.
  - FLUSH runs for L cycles.
  - done rises after edge N_ISSUE+L+1, and busy falls at the same edge.
- done stays high until the edge at which acc_sig=1 is sampled; it is low the following cycle.
- Minimum spacing between jobs: done→ack→IDLE→start is at least 2 cycles after done rises.
- Throughput: PAR_H results per CALC cycle. Disabled tail lanes idle.

## Configuration
- XD_SKIP_ADD_EN defined:
  - y_in_flat port present.
  - One fp16_add_wrapper per lane, fed by the multiplier output.
  - Tag depth covers M_LAT+A_LAT+2.
  - out = y_in + D·x.
- XD_SKIP_ADD_EN undefined:
  - No y_in_flat port and no adders.
  - out = D·x, with L = M_LAT+1.

## Test plan
- Scale only, macro off, B=1, H=4, P=4, PAR_H=4: x all 0x4000 (2.0), D all 0x3800 (0.5) → all 16 outputs 0x3C00. done rises N_ISSUE+L+1 = 4+7+1 = 12 edges after start.
- Fused add, macro on, same shape: x=0x4000, D=0x3800, y_in=0x4000 → all outputs 0x4200 (3.0). done timing uses L = M_LAT+A_LAT+2.
- Ragged heads, H=5, PAR_H=4, P=2: D[h] = {0x3C00, 0x4000, 0x3800, 0xBC00, 0x4000}, x all 0x3C00 → out[h][p] = D[h].
  - N_ISSUE = 4.
  - Lanes 1–3 in the second group never write; check that no out-of-range index is touched.
- Handshake: start pulses while busy and in DONE are ignored. acc_sig and start asserted together in DONE → IDLE with no new job. A later start runs normally and overwrites out_flat.
- Reset mid-CALC: drop rst_n at issue 3 → out_flat=0, done=0, busy=0 immediately. After release, no writes occur until a new start; the full job then matches the first test.
- Special values: x=0x7C00 (+Inf) with D=0x0000 → out=NaN as produced by the wrapper IP. x=0x8000 with D=0x3C00 → 0x8000.

Source files
------------

// File: rtl/xd_skip_fma.sv
// D-skip scale stage: out[b,h,p] = D[h]*x[b,h,p] over PAR_H FP16 lanes, ragged heads.
// Define XD_SKIP_ADD_EN to fuse the residual add (out = y_in + D*x).
module xd_skip_lane #(
  parameter int DW = 16,
  parameter int TW = 8,
  parameter int L  = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_i,
  input  logic [TW-1:0] tag_i,
  input  logic [DW-1:0] d_i,
  input  logic [DW-1:0] x_i,
`ifdef XD_SKIP_ADD_EN
  input  logic [DW-1:0] y_i,
`endif
  output logic          vld_o,
  output logic [TW-1:0] tag_o,
  output logic [DW-1:0] res_o
);
  localparam int STAGES = L - 1;

  // Denormal operands are flushed to zero; results round to nearest even.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic s; logic [21:0] pr; logic [9:0] f; logic g, st; logic [10:0] r; int ei;
    s = a[15] ^ b[15];
    if ((a[14:10] == 5'h1f && |a[9:0]) || (b[14:10] == 5'h1f && |b[9:0])) return 16'h7E00;
    if (a[14:10] == 5'h1f || b[14:10] == 5'h1f)
      return (a[14:10] == 5'h0 || b[14:10] == 5'h0) ? 16'h7E00 : {s, 5'h1f, 10'h0};
    if (a[14:10] == 5'h0 || b[14:10] == 5'h0) return {s, 15'h0};
    pr = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    ei = int'(a[14:10]) + int'(b[14:10]) - 15 + int'(pr[21]);
    if (pr[21]) begin f = pr[20:11]; g = pr[10]; st = |pr[9:0]; end
    else        begin f = pr[19:10]; g = pr[9];  st = |pr[8:0]; end
    r = {1'b0, f} + {10'h0, g & (st | f[0])};
    if (r[10]) ei = ei + 1;
    if (ei >= 31) return {s, 5'h1f, 10'h0};
    if (ei <= 0) return {s, 15'h0};
    return {s, 5'(ei), r[9:0]};
  endfunction

`ifdef XD_SKIP_ADD_EN
  function automatic logic [15:0] fadd(input logic [15:0] a0, input logic [15:0] b0);
    logic [15:0] a, b; logic [4:0] d; logic [25:0] xa, xb, sm;
    logic [9:0] f; logic g, st, st0; logic [10:0] r; int ei, lp;
    if ((a0[14:10] == 5'h1f && |a0[9:0]) || (b0[14:10] == 5'h1f && |b0[9:0])) return 16'h7E00;
    if (a0[14:10] == 5'h1f && b0[14:10] == 5'h1f) return (a0[15] != b0[15]) ? 16'h7E00 : a0;
    if (a0[14:10] == 5'h1f) return a0;
    if (b0[14:10] == 5'h1f) return b0;
    if (a0[14:10] == 5'h0 && b0[14:10] == 5'h0) return {a0[15] & b0[15], 15'h0};
    if (a0[14:10] == 5'h0) return b0;
    if (b0[14:10] == 5'h0) return a0;
    if (a0[14:0] >= b0[14:0]) begin a = a0; b = b0; end
    else                      begin a = b0; b = a0; end
    d  = a[14:10] - b[14:10];
    xa = {2'b01, a[9:0], 14'h0};
    // Beyond 14 places the smaller operand only contributes a sticky bit.
    xb = (d > 5'd14) ? 26'd1 : ({2'b01, b[9:0], 14'h0} >> d);
    sm = (a[15] == b[15]) ? xa + xb : xa - xb;
    if (sm == 26'h0) return 16'h0;
    lp = 0;
    for (int i = 0; i < 26; i++) if (sm[i]) lp = i;
    ei  = int'(a[14:10]) + lp - 24;
    st0 = 1'b0;
    if (lp == 25) begin st0 = sm[0]; sm = sm >> 1; end
    else sm = sm << (24 - lp);
    f = sm[23:14]; g = sm[13]; st = (|sm[12:0]) | st0;
    r = {1'b0, f} + {10'h0, g & (st | f[0])};
    if (r[10]) ei = ei + 1;
    if (ei >= 31) return {a[15], 5'h1f, 10'h0};
    if (ei <= 0) return {a[15], 15'h0};
    return {a[15], 5'(ei), r[9:0]};
  endfunction
`endif

  logic [DW-1:0]                res_head;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0][TW-1:0]      tag_pipe;
  logic [STAGES:0][DW-1:0]      res_pipe;

  // Arithmetic is evaluated at issue; the register chain supplies the full latency.
`ifdef XD_SKIP_ADD_EN
  assign res_head = fadd(y_i, fmul(d_i, x_i));
`else
  assign res_head = fmul(d_i, x_i);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      res_pipe <= '0;
    end else begin
      vld_pipe[0] <= vld_i;
      tag_pipe[0] <= tag_i;
      res_pipe[0] <= res_head;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
        res_pipe[s] <= res_pipe[s-1];
      end
    end
  end

  assign vld_o = vld_pipe[STAGES];
  assign tag_o = tag_pipe[STAGES];
  assign res_o = res_pipe[STAGES];
endmodule

module xd_skip_fma #(
  parameter int B     = 1,
  parameter int H     = 24,
  parameter int P     = 64,
  parameter int DW    = 16,
  parameter int M_LAT = 6,
  parameter int A_LAT = 11,
  parameter int PAR_H = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  acc_sig,
  input  logic [H*DW-1:0]       D_flat,
  input  logic [B*H*P*DW-1:0]   x_flat,
`ifdef XD_SKIP_ADD_EN
  input  logic [B*H*P*DW-1:0]   y_in_flat,
`endif
  output logic [B*H*P*DW-1:0]   out_flat,
  output logic                  busy,
  output logic                  done
);
  localparam int NE = B * H * P;
  localparam int TW = (NE > 1) ? $clog2(NE) : 1;
`ifdef XD_SKIP_ADD_EN
  localparam int L = M_LAT + A_LAT + 2;
`else
  localparam int L = M_LAT + 1;
`endif

  typedef enum logic [1:0] {IDLE, CALC, FLUSH, DONE} state_t;
  state_t state_q, state_d;

  logic [31:0] b_q, hg_q, p_q, fcnt_q;
  logic        last_grp, last_issue;
  logic [NE-1:0][DW-1:0]       out_q;
  logic [PAR_H-1:0]            l_vld_i, l_vld_o;
  logic [PAR_H-1:0][TW-1:0]    l_tag_i, l_tag_o;
  logic [PAR_H-1:0][DW-1:0]    l_d, l_x, l_res;
`ifdef XD_SKIP_ADD_EN
  logic [PAR_H-1:0][DW-1:0]    l_y;
`endif

  assign last_grp   = (hg_q + 32'(PAR_H)) >= 32'(H);
  assign last_issue = (p_q == 32'(P-1)) && last_grp && (b_q == 32'(B-1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = CALC;
      CALC:  if (last_issue) state_d = FLUSH;
      FLUSH: if (fcnt_q == 32'(L)) state_d = DONE;
      DONE:  if (acc_sig) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tail lanes of a ragged group read head 0 so every slice stays in range.
  always_comb begin
    l_vld_i = '0;
    l_tag_i = '0;
    l_d     = '0;
    l_x     = '0;
`ifdef XD_SKIP_ADD_EN
    l_y     = '0;
`endif
    for (int i = 0; i < PAR_H; i++) begin
      logic [31:0] h, hs, idx;
      h   = hg_q + 32'(i);
      hs  = (h < 32'(H)) ? h : 32'h0;
      idx = b_q * 32'(H*P) + hs * 32'(P) + p_q;
      l_vld_i[i] = (state_q == CALC) && (h < 32'(H));
      l_tag_i[i] = TW'(idx);
      l_d[i]     = D_flat[hs*DW +: DW];
      l_x[i]     = x_flat[idx*DW +: DW];
`ifdef XD_SKIP_ADD_EN
      l_y[i]     = y_in_flat[idx*DW +: DW];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      b_q     <= '0;
      hg_q    <= '0;
      p_q     <= '0;
      fcnt_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= (state_q == FLUSH) ? fcnt_q + 32'd1 : 32'd0;
      if (state_q == IDLE && start) begin
        b_q  <= '0;
        hg_q <= '0;
        p_q  <= '0;
      end else if (state_q == CALC) begin
        if (p_q == 32'(P-1)) begin
          p_q <= '0;
          if (last_grp) begin
            hg_q <= '0;
            b_q  <= b_q + 32'd1;
          end else begin
            hg_q <= hg_q + 32'(PAR_H);
          end
        end else begin
          p_q <= p_q + 32'd1;
        end
      end
      for (int i = 0; i < PAR_H; i++)
        if (l_vld_o[i]) out_q[l_tag_o[i]] <= l_res[i];
    end
  end

  for (genvar gi = 0; gi < PAR_H; gi++) begin : g_lane
    xd_skip_lane #(.DW(DW), .TW(TW), .L(L)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .vld_i (l_vld_i[gi]),
      .tag_i (l_tag_i[gi]),
      .d_i   (l_d[gi]),
      .x_i   (l_x[gi]),
`ifdef XD_SKIP_ADD_EN
      .y_i   (l_y[gi]),
`endif
      .vld_o (l_vld_o[gi]),
      .tag_o (l_tag_o[gi]),
      .res_o (l_res[gi])
    );
  end

  assign out_flat = out_q;
  assign busy     = (state_q == CALC) || (state_q == FLUSH);
  assign done     = (state_q == DONE);
endmodule

// File: tb/tb_xd_skip_fma.sv
// Directed bench for xd_skip_fma: a 4-head square shape and a 5-head ragged, 2-batch shape.
module tb_xd_skip_fma;
`ifdef XD_SKIP_ADD_EN
  localparam int L = 6 + 11 + 2;
  localparam logic [15:0] EXP_A = 16'h4200;
`else
  localparam int L = 6 + 1;
  localparam logic [15:0] EXP_A = 16'h3C00;
`endif

  logic clk = 1'b0;
  logic rst_n, st0, ack0, st1, ack1;
  logic [4*16-1:0]  D0;
  logic [16*16-1:0] x0, out0;
  logic [5*16-1:0]  D1;
  logic [20*16-1:0] x1, out1;
  logic busy0, done0, busy1, done1;
`ifdef XD_SKIP_ADD_EN
  logic [16*16-1:0] y0;
  logic [20*16-1:0] y1;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  xd_skip_fma #(.B(1), .H(4), .P(4), .DW(16), .M_LAT(6), .A_LAT(11), .PAR_H(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .acc_sig(ack0), .D_flat(D0), .x_flat(x0),
`ifdef XD_SKIP_ADD_EN
    .y_in_flat(y0),
`endif
    .out_flat(out0), .busy(busy0), .done(done0));

  xd_skip_fma #(.B(2), .H(5), .P(2), .DW(16), .M_LAT(6), .A_LAT(11), .PAR_H(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .acc_sig(ack1), .D_flat(D1), .x_flat(x1),
`ifdef XD_SKIP_ADD_EN
    .y_in_flat(y1),
`endif
    .out_flat(out1), .busy(busy1), .done(done1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Start a job, pulse start once while busy, count edges until done.
  task automatic run_job(input int u, input int exp_edges, input string tag);
    int cnt;
    logic d;
    @(negedge clk);
    if (u == 0) st0 = 1'b1; else st1 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0; st1 = 1'b0;
    chk({tag, " busy_on"}, (u == 0) ? busy0 : busy1, 1);
    cnt = 0;
    d = 1'b0;
    while (!d && cnt < 400) begin
      @(posedge clk); cnt++; #1;
      if (cnt == 2) begin
        if (u == 0) st0 = 1'b1; else st1 = 1'b1;
      end else begin
        st0 = 1'b0; st1 = 1'b0;
      end
      d = (u == 0) ? done0 : done1;
    end
    st0 = 1'b0; st1 = 1'b0;
    chk({tag, " done_edge"}, cnt, exp_edges);
    chk({tag, " busy_off"}, (u == 0) ? busy0 : busy1, 0);
  endtask

  task automatic ack(input int u, input string tag);
    @(negedge clk);
    if (u == 0) ack0 = 1'b1; else ack1 = 1'b1;
    @(posedge clk); #1;
    ack0 = 1'b0; ack1 = 1'b0;
    chk(tag, (u == 0) ? done0 : done1, 0);
  endtask

  task automatic chk_out0(input logic [15:0] e, input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s[%0d]", tag, i), out0[i*16 +: 16], e);
  endtask

  initial begin
    logic [15:0] rag [5];
    logic [15:0] rag2 [5];
    logic [15:0] v;
    rag  = '{16'h3C00, 16'h4000, 16'h3800, 16'hBC00, 16'h4000};
    rag2 = '{16'h4000, 16'h4400, 16'h3C00, 16'hC000, 16'h4400};
    rst_n = 1'b0; st0 = 1'b0; ack0 = 1'b0; st1 = 1'b0; ack1 = 1'b0;
    D0 = '0; x0 = '0; D1 = '0; x1 = '0;
`ifdef XD_SKIP_ADD_EN
    y0 = '0; y1 = '0;
`endif
    repeat (3) @(posedge clk); #1;
    chk("rst out0", {31'h0, |out0}, 0);
    chk("rst out1", {31'h0, |out1}, 0);
    chk("rst busy", busy0, 0);
    chk("rst done", done0, 0);
    @(negedge clk) rst_n = 1'b1;

    // Job A: 0.5 * 2.0 (plus 2.0 with the fused add)
    D0 = {4{16'h3800}};
    x0 = {16{16'h4000}};
`ifdef XD_SKIP_ADD_EN
    y0 = {16{16'h4000}};
`endif
    run_job(0, 4 + L + 1, "jobA");
    chk_out0(EXP_A, "jobA out");

    // start in DONE is ignored; start+ack together returns to IDLE with no job
    @(negedge clk) st0 = 1'b1;
    @(posedge clk); #1 st0 = 1'b0;
    chk("done hold", done0, 1);
    chk("done busy", busy0, 0);
    @(negedge clk) begin st0 = 1'b1; ack0 = 1'b1; end
    @(posedge clk); #1 begin st0 = 1'b0; ack0 = 1'b0; end
    chk("ack+start done", done0, 0);
    repeat (3) @(posedge clk); #1;
    chk("ack+start no job", busy0, 0);

    // Job B: Inf*0 on heads 0,1; -0*1 on heads 2,3
    D0 = {16'h3C00, 16'h3C00, 16'h0000, 16'h0000};
    x0 = {{8{16'h8000}}, {8{16'h7C00}}};
`ifdef XD_SKIP_ADD_EN
    y0 = {16{16'h8000}};
`endif
    run_job(0, 4 + L + 1, "jobB");
    for (int i = 0; i < 16; i++) begin
      v = out0[i*16 +: 16];
      if (i < 8) chk($sformatf("jobB nan[%0d]", i), {31'h0, (v[14:10] == 5'h1f) && (v[9:0] != 10'h0)}, 1);
      else       chk($sformatf("jobB negz[%0d]", i), v, 16'h8000);
    end
    ack(0, "jobB ack");

    // Ragged heads, two batches
    D1 = {16'h4000, 16'hBC00, 16'h3800, 16'h4000, 16'h3C00};
    x1 = {{10{16'h4000}}, {10{16'h3C00}}};
`ifdef XD_SKIP_ADD_EN
    y1 = {20{16'h8000}};
`endif
    run_job(1, 8 + L + 1, "rag");
    for (int b = 0; b < 2; b++)
      for (int h = 0; h < 5; h++)
        for (int p = 0; p < 2; p++)
          chk($sformatf("rag out[%0d][%0d][%0d]", b, h, p), out1[(b*10 + h*2 + p)*16 +: 16],
              (b == 0) ? rag[h] : rag2[h]);
    ack(1, "rag ack");

    // Reset during CALC, then a clean rerun of job A
    D0 = {4{16'h3800}};
    x0 = {16{16'h4000}};
`ifdef XD_SKIP_ADD_EN
    y0 = {16{16'h4000}};
`endif
    @(negedge clk) st0 = 1'b1;
    @(posedge clk); #1 st0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst out0", {31'h0, |out0}, 0);
    chk("midrst busy", busy0, 0);
    chk("midrst done", done0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (L + 5) @(posedge clk); #1;
    chk("postrst out0", {31'h0, |out0}, 0);
    chk("postrst busy", busy0, 0);
    run_job(0, 4 + L + 1, "jobC");
    chk_out0(EXP_A, "jobC out");
    ack(0, "jobC ack");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
